// File: rtl/seq_core_v2_if.sv
// Block-RAM port bundle for seq_core_v2: port A writes, port B reads with one-cycle latency.
// Latency: dob is valid the cycle after enb/addrb. Backpressure: none, the RAM always accepts.
interface seq_core_v2_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dia;
  logic              enb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] dob;

  modport master (output ena, wea, addra, dia, enb, addrb, input dob);
  modport slave  (input ena, wea, addra, dia, enb, addrb, output dob);
endinterface

// File: rtl/seq_core_v2.sv
// Multi-cycle fetch/decode/execute core over a dual-port block RAM. The SEQ_CORE_V2_JZ_EN macro enables op 7 (JZ).
// Latency: 5 cycles per instruction, 7 for RAM2REG. Backpressure: none, the RAM never stalls the core.
module seq_core_v2 #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 10,
  parameter int          REG_N    = 32,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  seq_core_v2_if.master     ram,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              illegal_op,
  output logic              halted
);

  localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;

  localparam logic [7:0] OP_NOP     = 8'd0;
  localparam logic [7:0] OP_JMP     = 8'd1;
  localparam logic [7:0] OP_RAM2REG = 8'd2;
  localparam logic [7:0] OP_REG2RAM = 8'd3;
  localparam logic [7:0] OP_IMM2REG = 8'd4;
  localparam logic [7:0] OP_ADD     = 8'd5;
  localparam logic [7:0] OP_HALT    = 8'd6;
`ifdef SEQ_CORE_V2_JZ_EN
  localparam logic [7:0] OP_JZ      = 8'd7;
`endif

  typedef enum logic [2:0] {
    S_F0, S_W0, S_F1, S_W1, S_EX, S_MR, S_MW, S_HLT
  } state_t;

  state_t state, nxt;

  logic [15:0]       word0;
  logic [DATA_W-1:0] word1;
  logic [DATA_W-1:0] rf [REG_N];

  logic [7:0]        op;
  logic [7:0]        rsel;
  logic [7:0]        bsel;
  logic [RIDX_W-1:0] rdx;
  logic [RIDX_W-1:0] bdx;
  logic              r_ok;
  logic              b_ok;
  logic              bad;
  logic [DATA_W-1:0] r_val;
  logic [DATA_W-1:0] b_val;
  logic [ADDR_W-1:0] target;

  assign op     = word0[15:8];
  assign rsel   = word0[7:0];
  assign bsel   = word1[7:0];
  assign rdx    = rsel[RIDX_W-1:0];
  assign bdx    = bsel[RIDX_W-1:0];
  assign r_ok   = {1'b0, rsel} < 9'(REG_N);
  assign b_ok   = {1'b0, bsel} < 9'(REG_N);
  assign r_val  = rf[rdx];
  assign b_val  = rf[bdx];
  assign target = word1[ADDR_W-1:0];

  // A bad register index makes any op illegal, even ones that ignore r.
  always_comb begin
    bad = 1'b0;
    case (op)
      OP_NOP, OP_JMP, OP_RAM2REG, OP_REG2RAM,
      OP_IMM2REG, OP_HALT:        bad = !r_ok;
      OP_ADD:                     bad = !r_ok || !b_ok;
`ifdef SEQ_CORE_V2_JZ_EN
      OP_JZ:                      bad = !r_ok;
`endif
      default:                    bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_F0;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_F0:  nxt = S_W0;
      S_W0:  nxt = S_F1;
      S_F1:  nxt = S_W1;
      S_W1:  nxt = S_EX;
      S_EX: begin
        if (bad)                    nxt = S_F0;
        else if (op == OP_RAM2REG)  nxt = S_MR;
        else if (op == OP_HALT)     nxt = S_HLT;
        else                        nxt = S_F0;
      end
      S_MR:  nxt = S_MW;
      S_MW:  nxt = S_F0;
      S_HLT: nxt = S_HLT;
      default: nxt = S_F0;
    endcase
  end

  // Outputs are forced low while rst is asserted so the RAM sees no access during reset.
  always_comb begin
    ram.ena    = 1'b0;
    ram.wea    = 1'b0;
    ram.addra  = '0;
    ram.dia    = '0;
    ram.enb    = 1'b0;
    ram.addrb  = '0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state)
        S_F0, S_F1: begin
          ram.enb   = 1'b1;
          ram.addrb = pc;
        end
        S_EX: begin
          retire     = bad || (op != OP_RAM2REG);
          illegal_op = bad;
          if (!bad && op == OP_REG2RAM) begin
            ram.ena   = 1'b1;
            ram.wea   = 1'b1;
            ram.addra = target;
            ram.dia   = r_val;
          end
        end
        S_MR: begin
          ram.enb   = 1'b1;
          ram.addrb = target;
        end
        S_MW:    retire = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= ADDR_W'(RESET_PC);
      word0  <= '0;
      word1  <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_W0: begin
          word0 <= ram.dob[15:0];
          pc    <= pc + 1'b1;
        end
        S_W1: begin
          word1 <= ram.dob;
          pc    <= pc + 1'b1;
        end
        S_EX: begin
          if (!bad) begin
            if (op == OP_JMP)  pc     <= target;
            if (op == OP_HALT) halted <= 1'b1;
`ifdef SEQ_CORE_V2_JZ_EN
            if (op == OP_JZ && r_val == '0) pc <= target;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) rf[i] <= '0;
    end else if (state == S_EX && !bad) begin
      if (op == OP_IMM2REG) rf[rdx] <= word1;
      if (op == OP_ADD)     rf[rdx] <= r_val + b_val;
    end else if (state == S_MW) begin
      rf[rdx] <= ram.dob;
    end
  end

endmodule

// File: tb/tb_seq_core_v2.sv
// Directed bench for seq_core_v2: behavioural block RAM, single-instruction vector table plus timing/wrap/reset sequences.
module tb_seq_core_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pc;
  logic        retire;
  logic        illegal_op;
  logic        halted;

  seq_core_v2_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  seq_core_v2 #(.DATA_W(16), .ADDR_W(10), .REG_N(32), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ram        (bus),
    .pc         (pc),
    .retire     (retire),
    .illegal_op (illegal_op),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];

  always @(posedge clk) begin
    if (bus.ena && bus.wea) mem[bus.addra] <= bus.dia;
    if (bus.enb) bus.dob <= mem[bus.addrb];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  tr_pc    [512];
  logic [9:0]  tr_addra [512];
  logic [9:0]  tr_addrb [512];
  logic [15:0] tr_dia   [512];
  logic        tr_ena   [512];
  logic        tr_enb   [512];
  logic        tr_ret   [512];
  logic        tr_ill   [512];
  logic        tr_hlt   [512];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem(input logic [15:0] fill);
    for (int a = 0; a < 1024; a++) mem[a] <= fill;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs from reset release; stops on halted, at stop_at, or at max_cyc. Called at a negedge.
  task automatic run(input int max_cyc, input int stop_at, output int last);
    rst  = 1'b0;
    last = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      #1;
      tr_pc[c]    = pc;
      tr_ena[c]   = bus.ena;
      tr_enb[c]   = bus.enb;
      tr_addra[c] = bus.addra;
      tr_addrb[c] = bus.addrb;
      tr_dia[c]   = bus.dia;
      tr_ret[c]   = retire;
      tr_ill[c]   = illegal_op;
      tr_hlt[c]   = halted;
      last = c;
      if (halted || c == stop_at) break;
      @(negedge clk);
    end
  endtask

  task automatic tally(input int last, output int rets, output int ills, output int bad);
    rets = 0; ills = 0; bad = 0;
    for (int c = 1; c <= last; c++) begin
      if (tr_ret[c]) rets++;
      if (tr_ill[c]) ills++;
      if ((tr_ena[c] && tr_enb[c]) || (tr_ill[c] && !tr_ret[c])) bad++;
    end
  endtask

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] exp_st;
    int          exp_ill;
    int          exp_ret;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int last, rets, ills, bad;

    // Harness: r1=0xFFFF, r2=0x0002, <vector>, REG2RAM r1->0x300, HALT. 0xDEAD means no store happened.
    vecs[0]  = '{16'h0000, 16'h0000, 16'hFFFF, 0, 5};  // NOP
    vecs[1]  = '{16'h0501, 16'h0002, 16'h0001, 0, 5};  // ADD wraps
    vecs[2]  = '{16'h0401, 16'h1234, 16'h1234, 0, 5};  // IMM2REG
    vecs[3]  = '{16'h0501, 16'h0020, 16'hFFFF, 1, 5};  // ADD index 32
    vecs[4]  = '{16'h0501, 16'h001F, 16'hFFFF, 0, 5};  // ADD index 31
    vecs[5]  = '{16'h0901, 16'h0000, 16'hFFFF, 1, 5};  // undefined op
    vecs[6]  = '{16'h0440, 16'h5555, 16'hFFFF, 1, 5};  // r=0x40
    vecs[7]  = '{16'h0201, 16'h0003, 16'h0002, 0, 5};  // RAM2REG from program word
    vecs[8]  = '{16'h0501, 16'h0001, 16'hFFFE, 0, 5};  // ADD r1,r1
    vecs[9]  = '{16'h0100, 16'h0008, 16'hDEAD, 0, 4};  // JMP to HALT
`ifdef SEQ_CORE_V2_JZ_EN
    vecs[10] = '{16'h0703, 16'h0008, 16'hDEAD, 0, 4};  // JZ r3==0 taken
    vecs[11] = '{16'h0701, 16'h0008, 16'hFFFF, 0, 5};  // JZ r1!=0 falls through
`else
    vecs[10] = '{16'h0703, 16'h0008, 16'hFFFF, 1, 5};
    vecs[11] = '{16'h0701, 16'h0008, 16'hFFFF, 1, 5};
`endif

    do_reset();
    #1;
    chk("reset_enb", 32'(bus.enb), 0);
    chk("reset_retire", 32'(retire), 0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      clear_mem(16'h0000);
      mem[0] <= 16'h0401; mem[1] <= 16'hFFFF;
      mem[2] <= 16'h0402; mem[3] <= 16'h0002;
      mem[4] <= vecs[i].w0; mem[5] <= vecs[i].w1;
      mem[6] <= 16'h0301; mem[7] <= 16'h0300;
      mem[8] <= 16'h0600; mem[9] <= 16'h0000;
      mem[10'h300] <= 16'hDEAD;
      run(200, 0, last);
      tally(last, rets, ills, bad);
      chk($sformatf("v%0d_halted", i), 32'(tr_hlt[last]), 1);
      chk($sformatf("v%0d_store", i), 32'(mem[10'h300]), 32'(vecs[i].exp_st));
      chk($sformatf("v%0d_illegal", i), 32'(ills), 32'(vecs[i].exp_ill));
      chk($sformatf("v%0d_retires", i), 32'(rets), 32'(vecs[i].exp_ret));
      chk($sformatf("v%0d_ports", i), 32'(bad), 0);
    end

    // Basic timing: IMM2REG retires in cycle 5, HALT in 10, halted visible from cycle 11.
    do_reset();
    clear_mem(16'h0000);
    mem[0] <= 16'h0400; mem[1] <= 16'h1234;
    mem[2] <= 16'h0600; mem[3] <= 16'h0000;
    run(100, 0, last);
    tally(last, rets, ills, bad);
    chk("t1_fetch_c1", {tr_enb[1], 6'd0, tr_addrb[1]}, {1'b1, 16'h0000});
    chk("t1_retire_c5", 32'(tr_ret[5]), 1);
    chk("t1_retire_c10", 32'(tr_ret[10]), 1);
    chk("t1_retires", 32'(rets), 2);
    chk("t1_halt_cycle", 32'(last), 11);

    // Halted must clear on reset.
    do_reset();
    #1;
    chk("t1_reset_halted", 32'(halted), 0);
    chk("t1_reset_pc", 32'(pc), 0);
    @(negedge clk);

    // Store / load round trip through RAM.
    clear_mem(16'h0000);
    mem[0] <= 16'h0403; mem[1] <= 16'h00FF;
    mem[2] <= 16'h0303; mem[3] <= 16'h0020;
    mem[4] <= 16'h0204; mem[5] <= 16'h0020;
    mem[6] <= 16'h0304; mem[7] <= 16'h0021;
    mem[8] <= 16'h0600; mem[9] <= 16'h0000;
    run(200, 0, last);
    tally(last, rets, ills, bad);
    chk("t2_store_port", {tr_ena[10], tr_enb[10], 4'd0, tr_addra[10]}, {2'b10, 14'h0020});
    chk("t2_store_data", 32'(tr_dia[10]), 32'h00FF);
    chk("t2_mr_read", {tr_enb[16], 5'd0, tr_addrb[16]}, {1'b1, 15'h0020});
    chk("t2_load_retire", {tr_ret[15], tr_ret[16], tr_ret[17]}, 3'b001);
    chk("t2_ram20", 32'(mem[10'h020]), 32'h00FF);
    chk("t2_ram21", 32'(mem[10'h021]), 32'h00FF);
    chk("t2_retires", 32'(rets), 5);
    chk("t2_halt_cycle", 32'(last), 28);
    chk("t2_ports", 32'(bad), 0);

    // pc wrap across the word1 fetch.
    do_reset();
    clear_mem(16'h0000);
    mem[0]      <= 16'h0100; mem[1]      <= 16'h03FE;
    mem[10'h3FE] <= 16'h0100; mem[10'h3FF] <= 16'h0010;
    mem[10'h010] <= 16'h0600; mem[10'h011] <= 16'h0000;
    run(100, 0, last);
    tally(last, rets, ills, bad);
    chk("t5_pc_c6", 32'(tr_pc[6]), 32'h3FE);
    chk("t5_fetch_3ff", 32'(tr_addrb[8]), 32'h3FF);
    chk("t5_pc_wrapped", 32'(tr_pc[10]), 0);
    chk("t5_pc_c11", 32'(tr_pc[11]), 32'h010);
    chk("t5_halt_cycle", 32'(last), 16);
    chk("t5_illegal", 32'(ills), 0);

    // Reset during MR abandons the load.
    do_reset();
    clear_mem(16'h0000);
    mem[0] <= 16'h0205; mem[1] <= 16'h0040;
    mem[10'h040] <= 16'hBEEF;
    run(50, 6, last);
    chk("t6_in_mr", {tr_enb[6], 5'd0, tr_addrb[6]}, {1'b1, 15'h0040});
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_reset_ports", {bus.enb, bus.ena, retire}, 3'b000);
    chk("t6_reset_pc", 32'(pc), 0);
    mem[0] <= 16'h0305; mem[1] <= 16'h0041;
    mem[2] <= 16'h0600; mem[3] <= 16'h0000;
    mem[10'h041] <= 16'hAAAA;
    @(negedge clk);
    run(100, 0, last);
    chk("t6_restart_fetch", {tr_enb[1], 6'd0, tr_addrb[1]}, {1'b1, 16'h0000});
    chk("t6_reg_unwritten", 32'(mem[10'h041]), 0);
    chk("t6_halted", 32'(tr_hlt[last]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
